// File: rtl/num_entry.sv
// ---------------------------------------------------------------------------
// calc_pkg / num_entry
//
// calc_pkg holds the operand format shared with the ALU:
//   value = significand (N BCD digits read as an integer) * 10^(exponent - (N-1))
//
// num_entry: keypad number-entry stage. Accumulates digits, decimal point and
// sign toggles from a key stream into BCD entry registers. On ENTER it
// left-aligns the significand, denormalises it if the exponent would go
// negative, and offers the result on a valid/ready port.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   key_i        in   key code (0-9 digit, A point, B sign, C clear, D enter,
//                     E/F accepted and ignored)
//   key_valid_i  in   key_i is valid
//   key_ready_o  out  a key is accepted this cycle (entry state only)
//   num_o        out  assembled operand, all-zero while num_valid_o is low
//   num_valid_o  out  operand available (registered)
//   num_ready_i  in   consumer takes the operand
// ---------------------------------------------------------------------------

package calc_pkg;

  parameter int unsigned NumDigits = 8;
  parameter int unsigned ExpWidth  = 4;

  typedef struct packed {
    logic                       sign;
    logic                       error;
    logic [ExpWidth-1:0]        exponent;
    logic [4*NumDigits-1:0]     significand;
  } num_t;

endpackage

module num_entry
  import calc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] key_i,
  input  logic       key_valid_i,
  output logic       key_ready_o,
  output num_t       num_o,
  output logic       num_valid_o,
  input  logic       num_ready_i
);

  localparam int unsigned N  = NumDigits;
  localparam int unsigned DW = 4 * N;
  localparam int unsigned TW = ExpWidth + 2;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned FW = 6;
  // Any t <= -N shifts every digit out, so clamping there keeps the result
  // exact while keeping arbitrarily long leading-zero fractions in range.
  localparam int          TMin = -int'(N);

  localparam logic [3:0] KeyPoint = 4'hA;
  localparam logic [3:0] KeySign  = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;
  localparam logic [3:0] KeyEnter = 4'hD;

  typedef enum logic [1:0] {
    StEntry  = 2'd0,
    StAlign  = 2'd1,
    StDenorm = 2'd2,
    StOut    = 2'd3
  } state_e;

  state_e                r_state, w_state_d;
  logic [DW-1:0]         r_dig, w_dig_d;
  logic [CW-1:0]         r_n, w_n_d;
  logic [FW-1:0]         r_f, w_f_d;
  logic                  r_pt, w_pt_d;
  logic                  r_sign, w_sign_d;
  logic                  r_err, w_err_d;
  logic signed [TW-1:0]  r_t, w_t_d;
  logic                  r_valid, w_valid_d;

  logic                  w_accept;
  logic                  w_dig_zero;
  logic                  w_msd_zero;
  int                    w_t_int;

  assign key_ready_o = (r_state == StEntry);
  assign num_valid_o = r_valid;
  assign w_accept    = key_valid_i && key_ready_o;
  assign w_dig_zero  = (r_dig == '0);
  assign w_msd_zero  = (r_dig[DW-1 -: 4] == 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StEntry;
      r_dig   <= '0;
      r_n     <= '0;
      r_f     <= '0;
      r_pt    <= 1'b0;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
      r_t     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_dig   <= w_dig_d;
      r_n     <= w_n_d;
      r_f     <= w_f_d;
      r_pt    <= w_pt_d;
      r_sign  <= w_sign_d;
      r_err   <= w_err_d;
      r_t     <= w_t_d;
      r_valid <= w_valid_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_dig_d   = r_dig;
    w_n_d     = r_n;
    w_f_d     = r_f;
    w_pt_d    = r_pt;
    w_sign_d  = r_sign;
    w_err_d   = r_err;
    w_t_d     = r_t;
    w_valid_d = r_valid;
    w_t_int   = int'(r_n) - 1 - int'(r_f);
    if (w_t_int < TMin) begin
      w_t_int = TMin;
    end

    unique case (r_state)
      StEntry: begin
        if (w_accept) begin
          if (key_i < 4'd10) begin
            if ((r_n == '0) && (key_i == 4'd0)) begin
              // Leading zero: only counts as a fraction position.
              if (r_pt && (r_f != '1)) begin
                w_f_d = r_f + 1'b1;
              end
            end else if (r_n < CW'(N)) begin
              w_dig_d = {r_dig[DW-5:0], key_i};
              w_n_d   = r_n + 1'b1;
              if (r_pt && (r_f != '1)) begin
                w_f_d = r_f + 1'b1;
              end
            end else if (!r_pt) begin
              // Integer part too long to represent.
              w_err_d = 1'b1;
            end
          end else if (key_i == KeyPoint) begin
            w_pt_d = 1'b1;
          end else if (key_i == KeySign) begin
            w_sign_d = ~r_sign;
          end else if (key_i == KeyClear) begin
            w_dig_d  = '0;
            w_n_d    = '0;
            w_f_d    = '0;
            w_pt_d   = 1'b0;
            w_sign_d = 1'b0;
            w_err_d  = 1'b0;
            w_t_d    = '0;
          end else if (key_i == KeyEnter) begin
            w_t_d     = TW'(w_t_int);
            w_state_d = StAlign;
          end
        end
      end

      StAlign: begin
        if (!w_dig_zero && w_msd_zero) begin
          w_dig_d = {r_dig[DW-5:0], 4'd0};
        end else begin
          w_state_d = StDenorm;
        end
      end

      StDenorm: begin
        if ((r_t < 0) && !w_dig_zero) begin
          // Truncating shift toward the denormal form at exponent 0.
          w_dig_d = {4'd0, r_dig[DW-1:4]};
          w_t_d   = r_t + $signed(TW'(1));
        end else begin
          w_state_d = StOut;
          w_valid_d = 1'b1;
          if (w_dig_zero) begin
            w_t_d = '0;
          end
        end
      end

      StOut: begin
        if (r_valid && num_ready_i) begin
          w_state_d = StEntry;
          w_valid_d = 1'b0;
          w_dig_d   = '0;
          w_n_d     = '0;
          w_f_d     = '0;
          w_pt_d    = 1'b0;
          w_sign_d  = 1'b0;
          w_err_d   = 1'b0;
          w_t_d     = '0;
        end
      end

      default: begin
        w_state_d = StEntry;
      end
    endcase
  end

  always_comb begin
    num_o = '0;
    if (r_valid) begin
      // Zero has no sign.
      num_o.sign        = r_sign && !w_dig_zero;
      num_o.error       = r_err;
      num_o.exponent    = r_t[ExpWidth-1:0];
      num_o.significand = r_dig;
    end
  end

endmodule

// File: tb/tb_num_entry.sv
module tb_num_entry;
  import calc_pkg::*;

  localparam int N = NumDigits;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] key_i;
  logic       key_valid_i;
  logic       key_ready_o;
  num_t       num_o;
  logic       num_valid_o;
  logic       num_ready_i;

  always #5 clk_i = ~clk_i;

  num_entry dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .num_o       (num_o),
    .num_valid_o (num_valid_o),
    .num_ready_i (num_ready_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the number as typed, kept as a list of digits.
  int unsigned m_dig[$];
  int          m_f;
  bit          m_pt, m_sign, m_err;

  // Expected result of the pending entry.
  logic [31:0] e_sig;
  int          e_exp;
  bit          e_sign, e_err;
  int          e_lat;

  function automatic void m_clear();
    m_dig.delete();
    m_f    = 0;
    m_pt   = 0;
    m_sign = 0;
    m_err  = 0;
  endfunction

  function automatic void m_key(input logic [3:0] k);
    if (k < 4'd10) begin
      if (m_dig.size() == 0 && k == 4'd0) begin
        if (m_pt) m_f++;
      end else if (m_dig.size() < N) begin
        m_dig.push_back(int'(k));
        if (m_pt) m_f++;
      end else if (!m_pt) begin
        m_err = 1;
      end
    end else if (k == 4'hA) m_pt = 1;
    else if (k == 4'hB) m_sign = !m_sign;
    else if (k == 4'hC) m_clear();
  endfunction

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Value arithmetic: significand = typed digits scaled to N places; a
  // negative exponent divides by powers of ten (truncating).
  function automatic void m_enter();
    int     n, t, s;
    longint sig;
    n   = m_dig.size();
    t   = n - 1 - m_f;
    sig = 0;
    foreach (m_dig[i]) sig = sig * 10 + longint'(m_dig[i]);
    for (int i = 0; i < N - n; i++) sig = sig * 10;
    s = 0;
    while (t < 0 && sig != 0) begin
      sig = sig / 10;
      t++;
      s++;
    end
    if (sig == 0) t = 0;
    e_sig  = to_bcd(sig);
    e_exp  = t;
    e_sign = m_sign && (sig != 0);
    e_err  = m_err;
    e_lat  = (n == 0) ? 2 : (N - n) + 1 + s + 1;
  endfunction

  task automatic press(input logic [3:0] k);
    if (key_ready_o !== 1'b1) $display("FAIL press_ready: got %0b expected 1", key_ready_o);
    key_i       = k;
    key_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    m_key(k);
  endtask

  task automatic run_seq(input logic [3:0] ks[$]);
    foreach (ks[i]) press(ks[i]);
  endtask

  // ENTER, wait for the operand, check it, optionally hold it under
  // backpressure with a key pending, then take it.
  task automatic finish_entry(input string tag, input int hold);
    int   cyc;
    bit   seen;
    num_t held;
    m_enter();
    key_i       = 4'hD;
    key_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 64) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (cyc == 1) chk({tag, "_busy_ready"}, key_ready_o, 0);
      if (num_valid_o === 1'b1) seen = 1;
    end
    chk({tag, "_latency"}, seen ? cyc : -1, e_lat);
    if (seen) begin
      chk({tag, "_sig"}, num_o.significand, e_sig);
      chk({tag, "_exp"}, num_o.exponent, e_exp);
      chk({tag, "_sign"}, num_o.sign, e_sign);
      chk({tag, "_err"}, num_o.error, e_err);
      if (hold > 0) begin
        held        = num_o;
        key_i       = 4'h5;
        key_valid_i = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk_i);
          #1;
          chk({tag, "_hold_num"}, num_o, {e_sign, e_err, 4'(e_exp), e_sig});
          chk({tag, "_hold_ready"}, key_ready_o, 0);
          chk({tag, "_hold_valid"}, num_valid_o, 1);
        end
        chk({tag, "_hold_stable"}, num_o, held);
      end
      num_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      num_ready_i = 1'b0;
      key_valid_i = 1'b0;
      chk({tag, "_taken_valid"}, num_valid_o, 0);
      chk({tag, "_taken_ready"}, key_ready_o, 1);
      chk({tag, "_taken_num"}, num_o, '0);
    end else begin
      rst_i = 1'b1;
      #1;
      rst_i = 1'b0;
    end
    m_clear();
  endtask

  initial begin
    logic [3:0] q[$];
    int         len, r;

    rst_i       = 1'b1;
    key_i       = 4'h0;
    key_valid_i = 1'b0;
    num_ready_i = 1'b0;
    m_clear();
    #12;
    chk("rst_ready", key_ready_o, 1);
    chk("rst_valid", num_valid_o, 0);
    chk("rst_num", num_o, '0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    q = {4'h1, 4'h2, 4'h3};
    run_seq(q);
    chk("int_model_lat", e_lat, e_lat);
    finish_entry("int", 0);

    q = {4'h0, 4'hA, 4'h0, 4'h5};
    run_seq(q);
    finish_entry("denorm", 0);

    q = {4'hB, 4'h4, 4'h2, 4'hB, 4'hB};
    run_seq(q);
    finish_entry("sign", 0);

    q = {4'hB, 4'h0, 4'h0};
    run_seq(q);
    finish_entry("negzero", 0);

    q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    run_seq(q);
    finish_entry("ovf", 0);

    q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'h9, 4'h9};
    run_seq(q);
    finish_entry("fracdrop", 0);

    q = {4'h6, 4'hA, 4'h2};
    run_seq(q);
    finish_entry("bp", 10);
    q = {4'h2};
    run_seq(q);
    finish_entry("bp_fresh", 0);

    q = {4'h7, 4'hA, 4'hC, 4'h3};
    run_seq(q);
    finish_entry("clear", 0);

    q = {4'hE, 4'hF, 4'h9};
    run_seq(q);
    finish_entry("ignored", 0);

    // Async reset while aligning.
    q = {4'h1};
    run_seq(q);
    key_i       = 4'hD;
    key_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    chk("align_busy", key_ready_o, 0);
    rst_i = 1'b1;
    #1;
    chk("arst_ready", key_ready_o, 1);
    chk("arst_valid", num_valid_o, 0);
    chk("arst_num", num_o, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_clear();
    q = {4'h4};
    run_seq(q);
    finish_entry("post_rst", 0);

    // Random key streams.
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 12);
      q.delete();
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 55) q.push_back(4'($urandom_range(0, 9)));
        else if (r < 68) q.push_back(4'hA);
        else if (r < 78) q.push_back(4'hB);
        else if (r < 82) q.push_back(4'hC);
        else if (r < 88) q.push_back(4'($urandom_range(14, 15)));
        else q.push_back(4'h0);
      end
      run_seq(q);
      finish_entry("rand", (it % 5 == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/num_entry.md
# num_entry

Keypad number-entry stage that builds one `calc_pkg::num_t` operand from a stream of key codes and hands it to the ALU operand path, including `alu_add`. Digits, decimal point and sign toggles are accumulated in BCD. On ENTER a multi-cycle normalize step produces the same normalized form the ALU emits, then the operand is offered on a valid/ready port. The block sits between the keypad decoder and the operand registers feeding the ALU.

## Interface
- No parameters. Digit count is `calc_pkg::NumDigits` (N); the exponent width is that of `calc_pkg::num_t.exponent`.
- `clk_i`  in  1  Single clock; all state updates on its rising edge.
- `rst_i`  in  1  Reset, asynchronous and active-high.
- `key_i`  in  4  Key code:
  - 0–9: digit.
  - 4'hA: decimal point.
  - 4'hB: sign toggle.
  - 4'hC: clear.
  - 4'hD: enter.
  - 4'hE, 4'hF: ignored (accepted, no effect).
- `key_valid_i`  in  1  `key_i` is valid.
- `key_ready_o`  out  1  Block accepts a key; high exactly when the state is S_ENTRY.
- `num_o`  out  `num_t`  Assembled operand; forced to '0 when `num_valid_o` is low.
- `num_valid_o`  out  1  Registered; operand is available.
- `num_ready_i`  in  1  Consumer takes the operand.

## Operation
Value convention: value = S × 10^(exponent − (N−1)), where S is the significand read as an N-digit integer and exponent is unsigned.

Entry registers:
- `dig_q`: N BCD digits, right-aligned.
- `n_q`: significant digit count, 0..N.
- `f_q`: fraction digit count.
- `pt_q`: point seen.
- `sign_q`, `err_q`.

A key is accepted on a cycle with `key_valid_i && key_ready_o`.

S_ENTRY accepts keys:
- **Digit 0 with `n_q==0`:**
  - Dropped if `!pt_q`.
  - If `pt_q`, increments `f_q` only.
- **Other digit with `n_q<N`:** shifted into `dig_q` LSD; `n_q++`; `f_q++` if `pt_q`.
- **Digit with `n_q==N`:**
  - If `!pt_q`, sets `err_q`; digits unchanged.
  - If `pt_q`, dropped; no `f_q` change.
- **Point:** sets `pt_q`; a repeated point is ignored.
- **Sign:** toggles `sign_q`.
- **Clear:** zeroes all entry registers.
- **Enter:**
  - Latches t = n_q − 1 − f_q into a signed register of width exponent+2.
  - Goes to S_ALIGN.

S_ALIGN:
- Each cycle, if `dig_q != 0` and MSD == 0: shift `dig_q` left one digit and stay.
- Otherwise go to S_DENORM. t is not modified.

S_DENORM:
- While t < 0 and `dig_q != 0`: shift `dig_q` right one digit, t++.
- Otherwise go to S_OUT. The `num_valid_o` register is set on this transition.
- If `dig_q == 0`, force t = 0.

S_OUT:
- `num_o` = {sign, error, exponent = t[exp-1:0], significand = `dig_q`}.
- sign is forced 0 when the significand is 0; error = `err_q`.
- On `num_valid_o && num_ready_i`:
  - Next state S_ENTRY, `num_valid_o` ← 0.
  - All entry registers cleared.
- Outputs are held stable while not taken.

Width rules:
- t ≤ N−1 always, so no exponent overflow.
- Negative t produces a denormal at exponent 0. Digits shifted out are lost (truncation, no rounding).

## Timing
- **Reset (async, any state, including mid-S_ALIGN/S_DENORM/S_OUT):**
  - State S_ENTRY, all registers 0.
  - `key_ready_o` = 1, `num_valid_o` = 0, `num_o` = '0.
- Keys are accepted at most one per cycle. The effect is visible in the registers the cycle after acceptance.
- **Enter accepted at edge k:** `num_valid_o` is first high after edge k + (N−n_q) + 1 + max(0, −t) + 1.
  - With `dig_q == 0`, the first high is after edge k+2.
- `key_ready_o` is low from the cycle after ENTER until the cycle after the handshake.
- `num_ready_i` may be high before valid; the handshake counts only when both are high.
- Keys presented while not ready are not consumed. The source must hold them.

## Test plan
Scenarios use N = 8.
1. **Integer entry:** keys 1,2,3,D → significand 0x12300000, exponent 2, sign 0, error 0; `num_valid_o` rises 7 cycles after ENTER acceptance.
2. **Denormal:** keys 0,A,0,5,D → n=1, f=2, t=−2; significand 0x00500000, exponent 0; `num_valid_o` rises 11 cycles after ENTER.
3. **Sign handling:**
   - Keys B,4,2,B,B,D → sign 1, significand 0x42000000, exponent 1.
   - Keys B,0,0,D → sign 0, significand 0, exponent 0, valid 2 cycles after ENTER.
4. **Overflow:** digits 1..9 then D → error 1, significand 0x12345678, exponent 7. Extra fraction digits after 8 significant digits are silently dropped with error 0.
5. **Backpressure:**
   - Hold `num_ready_i`=0 for 10 cycles → `num_o` stable, `key_ready_o`=0, keys not consumed.
   - Then raise `num_ready_i` → next cycle `num_valid_o`=0, `key_ready_o`=1, a fresh entry starts from zero.
6. **Clear and reset:**
   - Keys 7,A,C,3,D → significand 0x30000000, exponent 0.
   - Assert `rst_i` mid-S_ALIGN → outputs return to reset values immediately, without waiting for a clock edge.
